// File: rtl/axi_read_response_if.sv
// Bundles the block-facing signals of the AXI R-channel transmitter: burst descriptor, internal beat source, AXI R channel.
// No latency of its own: wires only.
// Flow control: descriptor uses i_req_valid/o_req_ready, internal beats use i_data_valid/o_data_ready, R channel uses o_rvalid/i_rready.
//   slave  : the transmitter side (drives o_*, samples i_*)
//   master : the environment side (drives i_*, samples o_*)
interface axi_read_response_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 16
);
    logic                  i_req_valid;
    logic [ID_WIDTH-1:0]   i_req_id;
    logic [7:0]            i_req_len;
    logic                  o_req_ready;

    logic                  i_data_valid;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_data_err;
    logic                  o_data_ready;

    logic                  o_rvalid;
    logic [DATA_WIDTH-1:0] o_rdata;
    logic [1:0]            o_rresp;
    logic [ID_WIDTH-1:0]   o_rid;
    logic                  o_rlast;
    logic                  i_rready;

    modport slave (
        input  i_req_valid, i_req_id, i_req_len,
        output o_req_ready,
        input  i_data_valid, i_data, i_data_err,
        output o_data_ready,
        output o_rvalid, o_rdata, o_rresp, o_rid, o_rlast,
        input  i_rready
    );

    modport master (
        output i_req_valid, i_req_id, i_req_len,
        input  o_req_ready,
        output i_data_valid, i_data, i_data_err,
        input  o_data_ready,
        input  o_rvalid, o_rdata, o_rresp, o_rid, o_rlast,
        output i_rready
    );
endinterface

// File: rtl/axi_read_response.sv
// AXI read-data (R) channel transmitter: one burst at a time, beats buffered in a FIFO_DEPTH-entry FIFO, RLAST and SLVERR mapping.
// Latency: a beat accepted at edge N is presented on R (o_rvalid=1) in the cycle after edge N.
// Backpressure: i_rready low holds the R beat stable; o_data_ready drops when the FIFO is full or all len+1 beats were taken.
// Ports: clk, r_reset (synchronous, active-low), bus (axi_read_response_if.slave: descriptor, internal beat source, AXI R channel).
module axi_read_response #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                r_reset,
    axi_read_response_if.slave  bus
);
    localparam int             AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [7:0]            accept_left;   // beats still to accept, minus one
    logic [7:0]            send_left;     // beats still to send, minus one
    logic                  accept_done;   // all len+1 beats have been accepted

    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_err;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;

    logic                  data_ready;
    logic                  rvalid;
    logic                  push;
    logic                  pop;

    // Everything below is a function of registered state only, so the
    // R outputs are stable for the whole cycle and hold while stalled.
    assign data_ready = (state == BURST) && (count != FULL_CNT) && !accept_done;
    assign rvalid     = (count != '0);
    assign push       = bus.i_data_valid && data_ready;
    assign pop        = rvalid && bus.i_rready;

    assign bus.o_req_ready  = (state == IDLE);
    assign bus.o_data_ready = data_ready;
    assign bus.o_rvalid     = rvalid;
    // The storage is not reset; gate the head so the bus reads zero when idle.
    assign bus.o_rdata      = rvalid ? mem_data[rd_ptr] : '0;
    assign bus.o_rresp      = (rvalid && mem_err[rd_ptr]) ? 2'b10 : 2'b00;
    assign bus.o_rid        = rid_q;
    assign bus.o_rlast      = rvalid && (send_left == 8'd0);

    // Beat storage, written only on a push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= bus.i_data;
            mem_err[wr_ptr]  <= bus.i_data_err;
        end
    end

    always_ff @(posedge clk) begin
        if (!r_reset) begin
            state       <= IDLE;
            rid_q       <= '0;
            accept_left <= '0;
            send_left   <= '0;
            accept_done <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            // Pointers wrap naturally because FIFO_DEPTH is a power of two.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (bus.i_req_valid) begin
                        rid_q       <= bus.i_req_id;
                        accept_left <= bus.i_req_len;
                        send_left   <= bus.i_req_len;
                        accept_done <= 1'b0;
                        state       <= BURST;
                    end
                end
                BURST: begin
                    // Counters hold len-minus-progress; stopping at zero keeps
                    // len=255 from wrapping.
                    if (push) begin
                        if (accept_left == 8'd0) begin
                            accept_done <= 1'b1;
                        end else begin
                            accept_left <= accept_left - 8'd1;
                        end
                    end
                    if (pop) begin
                        if (send_left == 8'd0) begin
                            state <= IDLE;
                        end else begin
                            send_left <= send_left - 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
